// File: rtl/game_pkg.sv
// Shared types and constants for the game-state controller slice.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAYING   = 2'd1,
        GAME_OVER = 2'd2,
        WIN       = 2'd3
    } game_state_t;

    localparam int MAX_LEN = 7;
    localparam int SEG_W   = 7;
    localparam int LEN_W   = 3;
    localparam int SCORE_W = 8;

    // Thermometer decode: bit i set iff i < len.
    function automatic logic [SEG_W-1:0] thermo(input logic [LEN_W-1:0] len);
        logic [SEG_W-1:0] m;
        m = '0;
        for (int i = 0; i < SEG_W; i++) begin
            m[i] = (i < int'(len));
        end
        return m;
    endfunction

endpackage

// File: rtl/game_state_fsm_if.sv
// Per-frame collision inputs and game-state outputs of the controller.
interface game_state_fsm_if;
    import game_pkg::*;

    logic                 frame_end;
    logic                 start_btn;
    logic                 player_dragon_collision;
    logic                 sword_dragon_collision;
    logic                 sheep_dragon_collision;

    logic [1:0]           game_state;
    logic [1:0]           lives;
    logic [SCORE_W-1:0]   score;
    logic [LEN_W-1:0]     dragon_len;
    logic [SEG_W-1:0]     active_segments;
    logic                 invulnerable;
    logic                 player_hit;
    logic                 sheep_respawn;

    modport master (
        output frame_end, start_btn,
        output player_dragon_collision, sword_dragon_collision, sheep_dragon_collision,
        input  game_state, lives, score, dragon_len, active_segments,
        input  invulnerable, player_hit, sheep_respawn
    );

    modport slave (
        input  frame_end, start_btn,
        input  player_dragon_collision, sword_dragon_collision, sheep_dragon_collision,
        output game_state, lives, score, dragon_len, active_segments,
        output invulnerable, player_hit, sheep_respawn
    );

endinterface

// File: rtl/invuln_timer.sv
// Frame-counting invulnerability window. The hit frame itself is the first
// frame of the window, so the counter is loaded with one less than the window
// length and the active flag is held separately.
module invuln_timer #(
    parameter int INVULN_FRAMES = 60
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic tick,
    input  logic clear,
    output logic active
);

    logic [7:0] cnt;

    // Counter and active flag; clear beats load, load beats tick.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            cnt    <= 8'd0;
            active <= 1'b0;
        end else if (load) begin
            cnt    <= 8'(INVULN_FRAMES - 1);
            active <= 1'b1;
        end else if (tick) begin
            if (cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end
            active <= (cnt > 8'd1);
        end
    end

endmodule

// File: rtl/game_state_fsm.sv
// Frame-rate game-state controller: play state, lives, score, dragon length
// and the active-segment mask, updated once per frame_end strobe.
module game_state_fsm #(
    parameter int START_LIVES   = 3,
    parameter int INVULN_FRAMES = 60,
    parameter int MAX_LEN       = 7
) (
    input  logic             clk,
    input  logic             reset,
    game_state_fsm_if.slave  bus
);
    import game_pkg::*;

    game_state_t          state_q, state_d;
    logic [1:0]           lives_q, lives_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [SEG_W-1:0]     mask_q;
    logic                 hit_q, hit_d;
    logic                 resp_q, resp_d;
    logic                 invuln;
    logic                 eval;
    logic                 hit_take;
    logic                 sword;
    logic                 sheep;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign eval     = (state_q == PLAYING) && bus.frame_end;
    assign sword    = bus.sword_dragon_collision;
    assign sheep    = bus.sheep_dragon_collision;
    assign hit_take = eval && bus.player_dragon_collision && !invuln;

    invuln_timer #(
        .INVULN_FRAMES (INVULN_FRAMES)
    ) u_invuln (
        .clk    (clk),
        .reset  (reset),
        .load   (hit_take),
        .tick   (eval),
        .clear  (state_d != PLAYING),
        .active (invuln)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: losing the last life outranks clearing the dragon.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (bus.start_btn) state_d = PLAYING;
            PLAYING: begin
                if (hit_take && lives_q == 2'd1) begin
                    state_d = GAME_OVER;
                end else if (eval && sword && len_q == 3'd1) begin
                    state_d = WIN;
                end
            end
            GAME_OVER,
            WIN:       if (bus.start_btn) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Output next-values: game rules applied to the flags of this frame.
    always_comb begin
        lives_d = lives_q;
        score_d = score_q;
        len_d   = len_q;
        hit_d   = 1'b0;
        resp_d  = 1'b0;
        if (state_q == IDLE && bus.start_btn) begin
            lives_d = 2'(START_LIVES);
            score_d = '0;
            len_d   = 3'd1;
        end else if (eval) begin
            if (sword) begin
                score_d = sat_inc(score_q);
            end
            // Sword and sheep together cancel; a lone sword at length 1 is a win.
            if (sword && !sheep && len_q != 3'd1) begin
                len_d = len_q - 3'd1;
            end else if (sheep && !sword && len_q < 3'(MAX_LEN)) begin
                len_d = len_q + 3'd1;
            end
            resp_d = sheep;
            if (hit_take) begin
                lives_d = lives_q - 2'd1;
                hit_d   = 1'b1;
            end
        end
    end

    // Registered outputs; mask tracks the registered length.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lives_q <= 2'(START_LIVES);
            score_q <= '0;
            len_q   <= 3'd1;
            mask_q  <= thermo(3'd1);
            hit_q   <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            lives_q <= lives_d;
            score_q <= score_d;
            len_q   <= len_d;
            mask_q  <= thermo(len_d);
            hit_q   <= hit_d;
            resp_q  <= resp_d;
        end
    end

    assign bus.game_state      = state_q;
    assign bus.lives           = lives_q;
    assign bus.score           = score_q;
    assign bus.dragon_len      = len_q;
    assign bus.active_segments = mask_q;
    assign bus.invulnerable    = invuln;
    assign bus.player_hit      = hit_q;
    assign bus.sheep_respawn   = resp_q;

endmodule

// File: tb/tb_game_state_fsm.sv
// Bench for game_state_fsm: a vector table, directed multi-cycle sequences
// and a randomized run against a rule-level reference model.
module tb_game_state_fsm;
    import game_pkg::*;

    localparam int START_LIVES   = 3;
    localparam int INVULN_FRAMES = 60;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    game_state_fsm_if bus();

    game_state_fsm #(
        .START_LIVES   (START_LIVES),
        .INVULN_FRAMES (INVULN_FRAMES),
        .MAX_LEN       (7)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: rules over whole frames, with invulnerability
    // expressed as distance from the frame of the last accepted hit.
    int m_st, m_lives, m_score, m_len;
    int m_hit, m_resp;
    int m_frame, m_hit_frame;
    bit m_hv;

    task automatic model_step(input bit rn, input bit st, input bit fe,
                              input bit pl, input bit sw, input bit sh);
        int nst;
        bit prot;
        m_hit  = 0;
        m_resp = 0;
        if (!rn) begin
            m_st = 0; m_lives = START_LIVES; m_score = 0; m_len = 1; m_hv = 0;
        end else if (m_st == 0) begin
            if (st) begin
                m_st = 1; m_lives = START_LIVES; m_score = 0; m_len = 1; m_hv = 0;
            end
        end else if (m_st == 1) begin
            if (fe) begin
                prot = m_hv && (m_frame - m_hit_frame < INVULN_FRAMES);
                nst  = 1;
                if (sw) begin
                    m_score = (m_score + 1 > 255) ? 255 : m_score + 1;
                    if (m_len == 1) nst = 3;
                end
                if (sw && sh) m_len = m_len;
                else if (sw && m_len > 1) m_len = m_len - 1;
                else if (sh && m_len < 7) m_len = m_len + 1;
                if (sh) m_resp = 1;
                if (pl && !prot) begin
                    m_lives = m_lives - 1;
                    m_hit = 1;
                    m_hv = 1;
                    m_hit_frame = m_frame;
                    if (m_lives == 0) nst = 2;
                end
                m_frame = m_frame + 1;
                m_st = nst;
                if (nst != 1) m_hv = 0;
            end
        end else begin
            if (st) m_st = 0;
        end
    endtask

    task automatic apply(input bit rn, input bit st, input bit fe,
                         input bit pl, input bit sw, input bit sh);
        reset                       = rn;
        bus.start_btn               = st;
        bus.frame_end               = fe;
        bus.player_dragon_collision = pl;
        bus.sword_dragon_collision  = sw;
        bus.sheep_dragon_collision  = sh;
        model_step(rn, st, fe, pl, sw, sh);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int st, input int lv, input int sc,
                              input int ln, input int mk, input int inv, input int hit,
                              input int resp);
        chk({tag, ".state"}, int'(bus.game_state), st);
        chk({tag, ".lives"}, int'(bus.lives), lv);
        chk({tag, ".score"}, int'(bus.score), sc);
        chk({tag, ".len"},   int'(bus.dragon_len), ln);
        chk({tag, ".mask"},  int'(bus.active_segments), mk);
        chk({tag, ".inv"},   int'(bus.invulnerable), inv);
        chk({tag, ".hit"},   int'(bus.player_hit), hit);
        chk({tag, ".resp"},  int'(bus.sheep_respawn), resp);
    endtask

    task automatic check_model(input string tag);
        int inv;
        inv = (m_st == 1 && m_hv && (m_frame - m_hit_frame < INVULN_FRAMES)) ? 1 : 0;
        check_outs(tag, m_st, m_lives, m_score, m_len, (1 << m_len) - 1, inv, m_hit, m_resp);
    endtask

    typedef struct {
        bit rn, st, fe, pl, sw, sh;
        int e_st, e_lv, e_sc, e_ln, e_mk, e_inv, e_hit, e_resp;
    } vec_t;

    vec_t tbl[11];
    int   resp_cnt;

    initial begin
        m_frame = 0; m_hit_frame = 0;
        // rn st fe pl sw sh | state lives score len mask inv hit resp
        tbl[0]  = '{0,0,0,0,0,0, 0,3,0,1,1,  0,0,0};
        tbl[1]  = '{1,1,0,0,0,0, 1,3,0,1,1,  0,0,0};
        tbl[2]  = '{1,0,1,0,0,1, 1,3,0,2,3,  0,0,1};
        tbl[3]  = '{1,0,0,0,0,0, 1,3,0,2,3,  0,0,0};
        tbl[4]  = '{1,0,1,0,0,1, 1,3,0,3,7,  0,0,1};
        tbl[5]  = '{1,0,1,0,0,1, 1,3,0,4,15, 0,0,1};
        tbl[6]  = '{1,0,1,0,1,0, 1,3,1,3,7,  0,0,0};
        tbl[7]  = '{1,0,1,0,1,0, 1,3,2,2,3,  0,0,0};
        tbl[8]  = '{1,0,0,1,1,1, 1,3,2,2,3,  0,0,0};
        tbl[9]  = '{1,1,0,0,0,0, 1,3,2,2,3,  0,0,0};
        tbl[10] = '{1,0,1,0,1,1, 1,3,3,2,3,  0,0,1};

        for (int i = 0; i < 11; i++) begin
            apply(tbl[i].rn, tbl[i].st, tbl[i].fe, tbl[i].pl, tbl[i].sw, tbl[i].sh);
            check_outs($sformatf("vec%0d", i), tbl[i].e_st, tbl[i].e_lv, tbl[i].e_sc,
                       tbl[i].e_ln, tbl[i].e_mk, tbl[i].e_inv, tbl[i].e_hit, tbl[i].e_resp);
        end

        // Invulnerability window: hit at K, repeated hits K+1..K+59 ignored.
        apply(1,0,1,1,0,0);
        check_outs("hitK", 1, 2, 3, 2, 3, 1, 1, 0);
        apply(1,0,0,0,0,0);
        chk("hitK.pulse_one_cycle", int'(bus.player_hit), 0);
        for (int j = 1; j <= 59; j++) begin
            apply(1,0,1,1,0,0);
            chk($sformatf("inv%0d.lives", j), int'(bus.lives), 2);
            chk($sformatf("inv%0d.hit", j), int'(bus.player_hit), 0);
            chk($sformatf("inv%0d.inv", j), int'(bus.invulnerable), (j < 59) ? 1 : 0);
            apply(1,0,0,0,0,0);
        end
        apply(1,0,1,1,0,0);
        check_outs("hitK60", 1, 1, 3, 2, 3, 1, 1, 0);

        // Wait out the new window while shrinking the dragon to length 1.
        apply(1,0,1,0,1,0);
        for (int j = 0; j < 58; j++) apply(1,0,1,0,0,0);
        chk("window2.inv", int'(bus.invulnerable), 0);

        // Last life and a killing sword on the same frame: GAME_OVER wins.
        apply(1,0,1,1,1,0);
        check_outs("gameover", 2, 0, 5, 1, 1, 0, 1, 0);
        apply(1,0,1,1,1,1);
        check_outs("gameover.ignore", 2, 0, 5, 1, 1, 0, 0, 0);
        apply(1,1,0,0,0,0);
        check_outs("gameover.to_idle", 0, 0, 5, 1, 1, 0, 0, 0);
        apply(1,1,0,0,0,0);
        check_outs("restart", 1, 3, 0, 1, 1, 0, 0, 0);

        // Lone sword at length 1 wins.
        apply(1,0,1,0,1,0);
        check_outs("win", 3, 3, 1, 1, 1, 0, 0, 0);
        apply(1,1,0,0,0,0);
        chk("win.to_idle", int'(bus.game_state), 0);
        apply(1,1,0,0,0,0);
        chk("restart2", int'(bus.game_state), 1);

        // Grow to 7, then seven more sheep frames at the cap.
        for (int j = 0; j < 6; j++) apply(1,0,1,0,0,1);
        chk("grow.len", int'(bus.dragon_len), 7);
        resp_cnt = 0;
        for (int j = 0; j < 7; j++) begin
            apply(1,0,1,0,0,1);
            resp_cnt += int'(bus.sheep_respawn);
        end
        check_outs("cap7", 1, 3, 0, 7, 127, 0, 0, 1);
        chk("cap7.resp_count", resp_cnt, 7);
        apply(1,0,1,0,1,1);
        check_outs("swordsheep", 1, 3, 1, 7, 127, 0, 0, 1);

        // Score saturation.
        for (int j = 0; j < 254; j++) apply(1,0,1,0,1,1);
        chk("sat.score255", int'(bus.score), 255);
        apply(1,0,1,0,1,0);
        check_outs("sat.hold", 1, 3, 255, 6, 63, 0, 0, 0);

        // Reset on the same edge as a frame with every flag set.
        apply(0,0,1,1,1,1);
        check_outs("reset_frame", 0, 3, 0, 1, 1, 0, 0, 0);

        // Randomized run against the reference model.
        for (int n = 0; n < 4000; n++) begin
            apply(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 2) == 0));
            check_model($sformatf("rand%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
